// File: rtl/calc_tag_tracker_if.sv
// rtl/calc_tag_tracker_if.sv - request/response taps and status bundle for calc_tag_tracker
interface calc_tag_tracker_if #(
  parameter int NUM_PORTS  = 4,
  parameter int CMD_WIDTH  = 4,
  parameter int TAG_WIDTH  = 2,
  parameter int RESP_WIDTH = 2
);
  localparam int PortW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS*CMD_WIDTH-1:0]     req_cmd_in;
  logic [NUM_PORTS*TAG_WIDTH-1:0]     req_tag_in;
  logic [NUM_PORTS*RESP_WIDTH-1:0]    resp_out;
  logic [NUM_PORTS*TAG_WIDTH-1:0]     tag_out;
  logic [NUM_PORTS*(TAG_WIDTH+1)-1:0] outstanding;
  logic                               idle;
  logic                               err_valid;
  logic [1:0]                         err_code;
  logic [PortW-1:0]                   err_port;
  logic [TAG_WIDTH-1:0]               err_tag;
  logic [2:0]                         err_sticky;
  logic [15:0]                        err_count;

  modport master (
    output req_cmd_in, req_tag_in, resp_out, tag_out,
    input  outstanding, idle, err_valid, err_code, err_port, err_tag, err_sticky, err_count
  );

  modport slave (
    input  req_cmd_in, req_tag_in, resp_out, tag_out,
    output outstanding, idle, err_valid, err_code, err_port, err_tag, err_sticky, err_count
  );
endinterface

// File: rtl/calc_tag_tracker.sv
// rtl/calc_tag_tracker.sv - per-port tag tracker with duplicate/orphan checks, optional timeout (TRACKER_TIMEOUT_EN)
module calc_tag_tracker #(
  parameter int NUM_PORTS  = 4,
  parameter int CMD_WIDTH  = 4,
  parameter int TAG_WIDTH  = 2,
  parameter int RESP_WIDTH = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              ifClk,
  input  logic              ifRst,
  calc_tag_tracker_if.slave bus
);
  localparam int NTags = 1 << TAG_WIDTH;
  localparam int PortW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CntW  = TAG_WIDTH + 1;

  logic [NTags-1:0]     valid_q [NUM_PORTS];
  logic [NTags-1:0]     valid_d [NUM_PORTS];
  logic [CntW-1:0]      count_q [NUM_PORTS];
  logic [CntW-1:0]      count_d [NUM_PORTS];
  logic                 err_valid_q, err_valid_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [PortW-1:0]     err_port_q, err_port_d;
  logic [TAG_WIDTH-1:0] err_tag_q, err_tag_d;
  logic [2:0]           err_sticky_q, err_sticky_d;
  logic [15:0]          err_count_q, err_count_d;
  logic [31:0]          n_events;
  logic [31:0]          count_sum;

`ifdef TRACKER_TIMEOUT_EN
  localparam int AgeW = $clog2(TIMEOUT + 1);
  logic [AgeW-1:0] age_q [NUM_PORTS][NTags];
  logic [AgeW-1:0] age_d [NUM_PORTS][NTags];
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Next state: retire responses against pre-edge bitmap, then record issues; pick one error to report
  always_comb begin
    logic [CMD_WIDTH-1:0]  cmd;
    logic [RESP_WIDTH-1:0] rsp;
    logic [TAG_WIDTH-1:0]  itag;
    logic [TAG_WIDTH-1:0]  rtag;
    logic                  issue;
    logic                  retire;
    logic                  orphan;
    logic                  dup;
    logic [NTags-1:0]      nv;
    logic [NTags-1:0]      tmo;
    cmd          = '0;
    rsp          = '0;
    itag         = '0;
    rtag         = '0;
    issue        = 1'b0;
    retire       = 1'b0;
    orphan       = 1'b0;
    dup          = 1'b0;
    nv           = '0;
    tmo          = '0;
    err_valid_d  = 1'b0;
    err_code_d   = 2'd0;
    err_port_d   = '0;
    err_tag_d    = '0;
    err_sticky_d = err_sticky_q;
    n_events     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cmd    = bus.req_cmd_in[p*CMD_WIDTH +: CMD_WIDTH];
      itag   = bus.req_tag_in[p*TAG_WIDTH +: TAG_WIDTH];
      rsp    = bus.resp_out[p*RESP_WIDTH +: RESP_WIDTH];
      rtag   = bus.tag_out[p*TAG_WIDTH +: TAG_WIDTH];
      issue  = |cmd;
      retire = (|rsp) && valid_q[p][rtag];
      orphan = (|rsp) && !valid_q[p][rtag];
      nv     = valid_q[p];
      if (retire) nv[rtag] = 1'b0;
      dup = issue && nv[itag];
      if (issue) nv[itag] = 1'b1;
      tmo = '0;
`ifdef TRACKER_TIMEOUT_EN
      for (int t = 0; t < NTags; t++) begin
        if (valid_q[p][t] && !(retire && rtag == TAG_WIDTH'(t)) &&
            age_q[p][t] == AgeW'(TIMEOUT - 1))
          tmo[t] = 1'b1;
        if (issue && itag == TAG_WIDTH'(t))
          age_d[p][t] = '0;
        else if (!nv[t])
          age_d[p][t] = '0;
        else if (age_q[p][t] != AgeW'(TIMEOUT))
          age_d[p][t] = age_q[p][t] + AgeW'(1);
        else
          age_d[p][t] = age_q[p][t];
      end
`endif
      valid_d[p] = nv;
      count_d[p] = '0;
      for (int t = 0; t < NTags; t++) begin
        count_d[p] = count_d[p] + CntW'(nv[t]);
        n_events   = n_events + 32'(tmo[t]);
      end
      n_events     = n_events + 32'(orphan) + 32'(dup);
      err_sticky_d = err_sticky_d | {|tmo, dup, orphan};
      if (!err_valid_d) begin
        if (orphan) begin
          err_valid_d = 1'b1;
          err_code_d  = 2'd1;
          err_port_d  = PortW'(p);
          err_tag_d   = rtag;
        end else if (dup) begin
          err_valid_d = 1'b1;
          err_code_d  = 2'd2;
          err_port_d  = PortW'(p);
          err_tag_d   = itag;
        end else begin
          for (int t = 0; t < NTags; t++) begin
            if (tmo[t] && !err_valid_d) begin
              err_valid_d = 1'b1;
              err_code_d  = 2'd3;
              err_port_d  = PortW'(p);
              err_tag_d   = TAG_WIDTH'(t);
            end
          end
        end
      end
    end
    count_sum   = 32'(err_count_q) + n_events;
    err_count_d = (count_sum > 32'h0000_FFFF) ? 16'hFFFF : count_sum[15:0];
  end

  // State registers; reset drops every outstanding tag without reporting anything
  always_ff @(posedge ifClk or negedge ifRst) begin
    if (!ifRst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        valid_q[p] <= '0;
        count_q[p] <= '0;
`ifdef TRACKER_TIMEOUT_EN
        for (int t = 0; t < NTags; t++) age_q[p][t] <= '0;
`endif
      end
      err_valid_q  <= 1'b0;
      err_code_q   <= 2'd0;
      err_port_q   <= '0;
      err_tag_q    <= '0;
      err_sticky_q <= 3'd0;
      err_count_q  <= 16'd0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        valid_q[p] <= valid_d[p];
        count_q[p] <= count_d[p];
`ifdef TRACKER_TIMEOUT_EN
        for (int t = 0; t < NTags; t++) age_q[p][t] <= age_d[p][t];
`endif
      end
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_port_q   <= err_port_d;
      err_tag_q    <= err_tag_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  // Flatten per-port counts and derive idle
  always_comb begin
    bus.outstanding = '0;
    bus.idle        = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.outstanding[p*CntW +: CntW] = count_q[p];
      if (count_q[p] != '0) bus.idle = 1'b0;
    end
  end

  assign bus.err_valid  = err_valid_q;
  assign bus.err_code   = err_code_q;
  assign bus.err_port   = err_port_q;
  assign bus.err_tag    = err_tag_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_calc_tag_tracker.sv
// tb/tb_calc_tag_tracker.sv - self-checking bench for calc_tag_tracker
module tb_calc_tag_tracker;
  localparam int NP  = 4;
  localparam int CW  = 4;
  localparam int TW  = 2;
  localparam int RW  = 2;
  localparam int NT  = 4;
  localparam int TMO = 8;
`ifdef TRACKER_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic ifClk = 1'b0;
  logic ifRst = 1'b0;
  always #5 ifClk = ~ifClk;

  calc_tag_tracker_if #(.NUM_PORTS(NP), .CMD_WIDTH(CW), .TAG_WIDTH(TW), .RESP_WIDTH(RW)) bus();

  calc_tag_tracker #(
    .NUM_PORTS(NP), .CMD_WIDTH(CW), .TAG_WIDTH(TW), .RESP_WIDTH(RW), .TIMEOUT(TMO)
  ) dut (
    .ifClk(ifClk),
    .ifRst(ifRst),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: sets of outstanding tags with issue timestamps
  bit          m_set [NP][NT];
  int          m_tiss[NP][NT];
  int          m_cyc;
  logic [2:0]  m_sticky;
  int          m_count;
  logic        e_ev;
  logic [1:0]  e_code, e_port, e_tag;

  task automatic model_reset();
    foreach (m_set[p, t]) begin
      m_set[p][t]  = 1'b0;
      m_tiss[p][t] = 0;
    end
    m_cyc = 0; m_sticky = 3'b000; m_count = 0;
    e_ev = 1'b0; e_code = 2'd0; e_port = 2'd0; e_tag = 2'd0;
  endtask

  task automatic note(input int p, input int code, input int t, inout int best, inout int n);
    int key;
    n++;
    m_sticky[code-1] = 1'b1;
    key = p * 64 + code * 8 + t;
    if (key < best) best = key;
  endtask

  task automatic model_edge(input logic [15:0] cmd, input logic [7:0] itag,
                            input logic [7:0] resp, input logic [7:0] rtag);
    bit pre[NP][NT];
    int best, n, it, rt;
    bit iss, rs, retired;
    pre = m_set; best = 1 << 30; n = 0;
    m_cyc++;
    for (int p = 0; p < NP; p++) begin
      it  = int'(itag[2*p +: 2]);
      rt  = int'(rtag[2*p +: 2]);
      iss = (cmd[4*p +: 4] != 4'd0);
      rs  = (resp[2*p +: 2] != 2'd0);
      retired = rs && pre[p][rt];
      if (rs && !pre[p][rt]) note(p, 1, rt, best, n);
      if (TEN) begin
        for (int t = 0; t < NT; t++)
          if (pre[p][t] && !(retired && rt == t) && (m_cyc - m_tiss[p][t] == TMO))
            note(p, 3, t, best, n);
      end
      if (retired) m_set[p][rt] = 1'b0;
      if (iss) begin
        if (m_set[p][it]) note(p, 2, it, best, n);
        m_set[p][it]  = 1'b1;
        m_tiss[p][it] = m_cyc;
      end
    end
    m_count = (m_count + n > 65535) ? 65535 : m_count + n;
    e_ev = (n > 0);
    if (e_ev) begin
      e_port = 2'(best / 64); e_code = 2'((best / 8) % 8); e_tag = 2'(best % 8);
    end else begin
      e_port = 2'd0; e_code = 2'd0; e_tag = 2'd0;
    end
  endtask

  function automatic logic [11:0] m_out();
    logic [11:0] r;
    r = '0;
    for (int p = 0; p < NP; p++)
      for (int t = 0; t < NT; t++)
        r[3*p +: 3] = r[3*p +: 3] + 3'(m_set[p][t]);
    return r;
  endfunction

  task automatic check_model(input string ctx);
    chk({ctx, "_out"},    32'(bus.outstanding), 32'(m_out()));
    chk({ctx, "_idle"},   32'(bus.idle),        32'(m_out() == 12'h000));
    chk({ctx, "_ev"},     32'(bus.err_valid),   32'(e_ev));
    chk({ctx, "_code"},   32'(bus.err_code),    32'(e_code));
    chk({ctx, "_port"},   32'(bus.err_port),    32'(e_port));
    chk({ctx, "_tag"},    32'(bus.err_tag),     32'(e_tag));
    chk({ctx, "_sticky"}, 32'(bus.err_sticky),  32'(m_sticky));
    chk({ctx, "_count"},  32'(bus.err_count),   32'(m_count));
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs settled
  task automatic apply(input logic [15:0] cmd, input logic [7:0] itag,
                       input logic [7:0] resp, input logic [7:0] rtag);
    bus.req_cmd_in = cmd; bus.req_tag_in = itag; bus.resp_out = resp; bus.tag_out = rtag;
    model_edge(cmd, itag, resp, rtag);
    @(posedge ifClk);
    @(negedge ifClk);
  endtask

  task automatic idle_inputs();
    bus.req_cmd_in = '0; bus.req_tag_in = '0; bus.resp_out = '0; bus.tag_out = '0;
  endtask

  task automatic check_err_clear(input string ctx);
    chk({ctx, "_out"},    32'(bus.outstanding), 32'h0);
    chk({ctx, "_idle"},   32'(bus.idle),        32'h1);
    chk({ctx, "_ev"},     32'(bus.err_valid),   32'h0);
    chk({ctx, "_code"},   32'(bus.err_code),    32'h0);
    chk({ctx, "_port"},   32'(bus.err_port),    32'h0);
    chk({ctx, "_tag"},    32'(bus.err_tag),     32'h0);
    chk({ctx, "_sticky"}, 32'(bus.err_sticky),  32'h0);
    chk({ctx, "_count"},  32'(bus.err_count),   32'h0);
  endtask

  typedef struct packed {
    logic [15:0] cmd;
    logic [7:0]  itag;
    logic [7:0]  resp;
    logic [7:0]  rtag;
    logic [11:0] out;
    logic        ev;
    logic [1:0]  code;
    logic [1:0]  port;
    logic [1:0]  tag;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rc;
    logic [7:0]  ri, rr, rt;
    vecs[0]  = '{16'h0100, 8'h30, 8'h00, 8'h00, 12'h040, 1'b0, 2'd0, 2'd0, 2'd0};
    vecs[1]  = '{16'h0000, 8'h00, 8'h00, 8'h00, 12'h040, 1'b0, 2'd0, 2'd0, 2'd0};
    vecs[2]  = '{16'h0000, 8'h00, 8'h00, 8'h00, 12'h040, 1'b0, 2'd0, 2'd0, 2'd0};
    vecs[3]  = '{16'h0000, 8'h00, 8'h00, 8'h00, 12'h040, 1'b0, 2'd0, 2'd0, 2'd0};
    vecs[4]  = '{16'h0000, 8'h00, 8'h10, 8'h30, 12'h000, 1'b0, 2'd0, 2'd0, 2'd0};
    vecs[5]  = '{16'h0001, 8'h01, 8'h00, 8'h00, 12'h001, 1'b0, 2'd0, 2'd0, 2'd0};
    vecs[6]  = '{16'h0001, 8'h01, 8'h00, 8'h00, 12'h001, 1'b1, 2'd2, 2'd0, 2'd1};
    vecs[7]  = '{16'h0010, 8'h00, 8'h00, 8'h00, 12'h009, 1'b0, 2'd0, 2'd0, 2'd0};
    vecs[8]  = '{16'h0010, 8'h00, 8'h40, 8'h80, 12'h009, 1'b1, 2'd2, 2'd1, 2'd0};
    vecs[9]  = '{16'h0010, 8'h00, 8'h04, 8'h00, 12'h009, 1'b0, 2'd0, 2'd0, 2'd0};
    vecs[10] = '{16'h0001, 8'h01, 8'h01, 8'h03, 12'h009, 1'b1, 2'd1, 2'd0, 2'd3};
    vecs[11] = '{16'h0000, 8'h00, 8'h01, 8'h01, 12'h008, 1'b0, 2'd0, 2'd0, 2'd0};

    idle_inputs();
    model_reset();
    ifRst = 1'b0;
    repeat (2) @(negedge ifClk);
    check_err_clear("reset");
    ifRst = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].cmd, vecs[i].itag, vecs[i].resp, vecs[i].rtag);
      chk($sformatf("vec%0d_out", i),  32'(bus.outstanding), 32'(vecs[i].out));
      chk($sformatf("vec%0d_idle", i), 32'(bus.idle),        32'(vecs[i].out == 12'h000));
      chk($sformatf("vec%0d_ev", i),   32'(bus.err_valid),   32'(vecs[i].ev));
      chk($sformatf("vec%0d_code", i), 32'(bus.err_code),    32'(vecs[i].code));
      chk($sformatf("vec%0d_port", i), 32'(bus.err_port),    32'(vecs[i].port));
      chk($sformatf("vec%0d_tag", i),  32'(bus.err_tag),     32'(vecs[i].tag));
    end
    chk("table_sticky", 32'(bus.err_sticky), 32'h3);
    chk("table_count",  32'(bus.err_count),  32'd5);

    // Three tags outstanding plus a duplicate, then reset lands between edges
    apply(16'h0111, 8'h20, 8'h00, 8'h00);
    chk("prerst_out",  32'(bus.outstanding), 32'h049);
    chk("prerst_ev",   32'(bus.err_valid),   32'h1);
    chk("prerst_code", 32'(bus.err_code),    32'h2);
    chk("prerst_port", 32'(bus.err_port),    32'h1);
    idle_inputs();
    ifRst = 1'b0;
    #1;
    check_err_clear("asyncrst");
    model_reset();
    @(negedge ifClk);
    ifRst = 1'b1;

    // Timeout window on port 0 tag 2
    apply(16'h0001, 8'h02, 8'h00, 8'h00);
    for (int k = 1; k <= 11; k++) begin
      apply(16'h0000, 8'h00, 8'h00, 8'h00);
      chk($sformatf("tmo_k%0d_ev", k), 32'(bus.err_valid), 32'(TEN && k == 8));
      if (TEN && k == 8) begin
        chk("tmo_code", 32'(bus.err_code), 32'h3);
        chk("tmo_port", 32'(bus.err_port), 32'h0);
        chk("tmo_tag",  32'(bus.err_tag),  32'h2);
      end
    end
    apply(16'h0000, 8'h00, 8'h01, 8'h02);
    chk("late_out", 32'(bus.outstanding), 32'h0);
    chk("late_ev",  32'(bus.err_valid),   32'h0);
    chk("late_sticky", 32'(bus.err_sticky), TEN ? 32'h4 : 32'h0);
    chk("late_count",  32'(bus.err_count),  TEN ? 32'h1 : 32'h0);

    // Randomised traffic against the reference model, with one mid-run reset
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        idle_inputs();
        ifRst = 1'b0;
        #1;
        check_err_clear("rndrst");
        model_reset();
        @(negedge ifClk);
        ifRst = 1'b1;
      end
      rc = '0; ri = '0; rr = '0; rt = '0;
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) == 0) rc[4*p +: 4] = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 4) == 0) rr[2*p +: 2] = 2'($urandom_range(1, 3));
        ri[2*p +: 2] = 2'($urandom_range(0, 3));
        rt[2*p +: 2] = 2'($urandom_range(0, 3));
      end
      apply(rc, ri, rr, rt);
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_tag_tracker.md
# calc_tag_tracker

Synthesizable, parametrised N-port request/response tag tracker that sits beside the calculator DUT on the testbench interface signals. It records every tag issued on each request port, retires tags as responses return, and flags duplicate issues, orphan responses and, optionally, response timeouts. It generalises the fixed four-port request/response view to NUM_PORTS channels and arbitrary field widths.

## Interface
- NUM_PORTS, 4: number of request/response channels.
- CMD_WIDTH, 4: request command width; zero means no request.
- TAG_WIDTH, 2: tag width; 2^TAG_WIDTH tags per port.
- RESP_WIDTH, 2: response code width; zero means no response.
- TIMEOUT, 64: cycles a tag may stay outstanding before timeout (TRACKER_TIMEOUT_EN only), 2..65535.

- ifClk  in  1  clock; all state updates on the rising edge.
- ifRst  in  1  asynchronous, active-low reset.
- req_cmd_in  in  NUM_PORTS*CMD_WIDTH  flattened commands; port p occupies [p*CMD_WIDTH +: CMD_WIDTH].
- req_tag_in  in  NUM_PORTS*TAG_WIDTH  flattened request tags.
- resp_out  in  NUM_PORTS*RESP_WIDTH  flattened DUT response codes.
- tag_out  in  NUM_PORTS*TAG_WIDTH  flattened DUT response tags.
- outstanding  out  NUM_PORTS*(TAG_WIDTH+1)  per-port count of outstanding tags.
- idle  out  1  high when every count is zero.
- err_valid  out  1  one-cycle pulse: an error is reported this cycle.
- err_code  out  2  1 = orphan response, 2 = duplicate issue, 3 = timeout, 0 = none.
- err_port  out  $clog2(NUM_PORTS) (min 1)  port of reported error.
- err_tag  out  TAG_WIDTH  tag of reported error.
- err_sticky  out  3  bit0 orphan, bit1 duplicate, bit2 timeout; set on any occurrence, cleared only by reset.
- err_count  out  16  count of error events, saturates at 16'hFFFF.

## Operation
- Per port: valid bitmap of 2^TAG_WIDTH bits, count register.
- Issue on port p: cmd != 0 at rising edge; sets valid[p][tag]. If already set and not retired this same cycle -> duplicate error; valid stays set.
- Response on port p: resp != 0; checked against pre-edge state. valid set -> clear; valid clear -> orphan error, no state change.
- Same port, same tag, issue and response in one cycle: response retires old entry, issue sets it again; net valid=1, count unchanged, no error. If tag was not outstanding: orphan reported, issue still recorded.
- Count = popcount of valid bitmap after update; idle = all counts zero.
- Several simultaneous errors: all set err_sticky bits and each adds 1 to err_count (saturating); err_valid/code/port/tag report one only, priority lowest port, then orphan > duplicate > timeout, then lowest tag.

## Timing
- Reset (ifRst low, async): valid bitmaps, counts, ages cleared; outputs: outstanding 0, idle 1, err_valid 0, err_code 0, err_port 0, err_tag 0, err_sticky 0, err_count 0. Reset asserted mid-operation discards all outstanding tags immediately; no errors generated for them.
- Inputs sampled at rising edge of ifClk (driver changes them on falling edge).
- Latency: registered outputs reflect an edge's events immediately after that edge (1 cycle from sample).
- err_valid high exactly one cycle per reporting edge; back-to-back errors give consecutive pulses.

## Configuration
- TRACKER_TIMEOUT_EN defined: per-tag age counter ($clog2(TIMEOUT+1) bits), cleared on issue, increments each cycle while valid, saturating at TIMEOUT. On the cycle age reaches TIMEOUT: timeout error, once per issue; tag stays outstanding until response (late response retires without orphan error).
- Undefined: no age counters in hardware; err_code 3 and err_sticky[2] never produced (err_sticky[2] tied 0); TIMEOUT ignored.

## Test plan
- Reset: ifRst low mid-stream with 3 tags outstanding -> outstanding 0, idle 1, err_count 0, all err outputs 0 asynchronously.
- Normal flow: port 2 issues cmd 1 tag 3, response 1 tag 3 four cycles later -> outstanding[2] 1 then 0, idle back to 1, no err_valid.
- Duplicate: port 0 issues tag 1 twice, no response -> err_valid pulse, err_code 2, err_port 0, err_tag 1, err_count 1, outstanding[0] 1.
- Orphan plus priority: port 3 responds tag 2 (not outstanding) while port 1 duplicates tag 0 same edge -> err_code 2, err_port 1; err_sticky 3'b011; err_count 2.
- Same-cycle retire/reissue: port 1 tag 0 outstanding, response and new issue tag 0 same edge -> no error, outstanding[1] stays 1.
- Timeout (TRACKER_TIMEOUT_EN, TIMEOUT 8): port 0 tag 2 issued, no response -> err_code 3 exactly 8 cycles later, single pulse; response at cycle 12 -> outstanding 0, no orphan.
